ysyx_24080014_lsu: RTL
======================

YSYX_24080014_LSU -- requirements
Module: ysyx_24080014_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of REQ-state cycles spent waiting for mem_ready.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, an access request from the execute stage.
REQ-005 SHALL have port in_ready, output, 1, asserted when the unit accepts a request.
REQ-006 SHALL have port in_load, input, 1, marking the request as a load.
REQ-007 SHALL have port in_store, input, 1, marking the request as a store.
REQ-008 SHALL have port in_funct3, input, 3, the RV32 width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-009 SHALL have port in_addr, input, 32, the byte address.
REQ-010 SHALL have port in_wdata, input, 32, the store data, right-aligned.
REQ-011 SHALL have port out_valid, output, 1, result valid toward writeback.
REQ-012 SHALL have port out_ready, input, 1, writeback accepts the result.
REQ-013 SHALL have port out_rdata, output, 32, the extended load data (0 for stores).
REQ-014 SHALL have port out_err, output, 1, flagging a misaligned, illegal or timed-out access.
REQ-015 SHALL have ports mem_wen (output, 1), mem_ren (output, 1), mem_valid (output, 1), mem_wmask (output, 8), mem_waddr (output, 32), mem_raddr (output, 32), mem_din (output, 32), mem_ready (input, 1) and mem_dout (input, 32), forming the initiator side of the memory responder handshake.

Function
REQ-016 SHALL implement FSM IDLE -> REQ -> ACK -> RESP -> IDLE; in_ready=1 only in IDLE.
REQ-017 SHALL latch the request in IDLE when in_valid=1, recording load/store, funct3, addr and wdata.
REQ-018 SHALL on the latching edge go to RESP with out_err=1 and no memory access if any of these hold: both in_load and in_store are set; h/hu with addr[0]=1; w with addr[1:0]!=0; or funct3 is illegal.
REQ-019 SHALL on the latching edge go to RESP with out_err=0 and out_rdata=0 when neither in_load nor in_store is set.
REQ-020 SHALL in REQ drive mem_wen (store) or mem_ren (load), never both, with mem_waddr=mem_raddr={addr[31:2],2'b00} and mem_valid=0.
REQ-021 SHALL in REQ drive the store mask as follows: sb gives 0001<<addr[1:0]; sh gives 0011<<{addr[1],1'b0}; sw gives 1111. mem_wmask[7:4]=0 always.
REQ-022 SHALL in REQ drive mem_din as wdata shifted left by 8*addr[1:0] bits, truncated to 32 bits.
REQ-023 SHALL in REQ, on mem_ready=1, capture mem_dout and go to ACK.
REQ-024 SHALL in ACK deassert mem_wen and mem_ren and assert mem_valid for exactly one cycle, then go to RESP.
REQ-025 SHALL form the load result from the captured word shifted right by 8*addr[1:0]: b/h sign-extend, bu/hu zero-extend, w unchanged.
REQ-026 SHALL hold out_valid=1 and stable out_rdata/out_err in RESP until out_ready=1, then go to IDLE on that edge.
REQ-027 SHALL count REQ cycles; when the count reaches TIMEOUT with no mem_ready, it goes to ACK with out_err=1 and out_rdata=0, and the counter clears on entry to REQ.
REQ-028 SHALL give a minimum latency of 4 cycles from acceptance to out_valid with a 1-cycle responder; a new request is accepted no earlier than the cycle after the RESP handshake.
REQ-029 SHALL ignore mem_ready outside REQ.

Reset
REQ-030 SHALL on rst=1 at an edge, including mid-transaction, enter IDLE, abandon any request and clear the counter.
REQ-031 SHALL reset outputs as follows: in_ready=1 is visible after release; out_valid, out_err, mem_wen, mem_ren and mem_valid are 0; out_rdata, mem_wmask, mem_waddr, mem_raddr and mem_din are 0.

Structure
REQ-032 SHALL place the FSM state encoding and the funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW) in shared package ysyx_24080014_pkg.
REQ-033 SHALL place mask and lane-shift generation in the combinational sub-module ysyx_24080014_lsu_align; the FSM and counter stay in the top module.

Verification
REQ-034 SHALL check sw: addr=0x80000004, wdata=0xDEADBEEF -> mem_wen=1, wmask=0x0F, waddr=0x80000004, din=0xDEADBEEF; one mem_valid pulse; out_valid with err=0.
REQ-035 SHALL check sb: addr=0x80000003, wdata=0x000000A5 -> wmask=0x08, din=0xA5000000.
REQ-036 SHALL check lb and lhu: mem_dout=0x80FF7F01 at addr ...02; lb -> out_rdata=0xFFFFFFFF; lhu at ...02 -> 0x000080FF.
REQ-037 SHALL check a misaligned lw: addr=0x80000002 -> no mem_ren, out_err=1 on the cycle after acceptance.
REQ-038 SHALL check timeout: with TIMEOUT=4 and mem_ready held 0 -> mem_ren high for 4 cycles, then mem_valid pulse, then out_err=1.
REQ-039 SHALL check reset mid-transaction: rst asserted during REQ -> mem_ren=0 and in_ready=1 after release; the next lw completes normally.

Source files
------------

// File: rtl/ysyx_24080014_pkg.sv
// Shared LSU types: FSM states, RV32 load/store width codes
// and the request legality check used at acceptance.
package ysyx_24080014_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // A request with neither load nor store set is a legal no-op.
    function automatic logic access_bad(
        input logic       ld,
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic legal;
        logic mis;
        legal = st ? (f3 == SB || f3 == SH || f3 == SW)
                   : (f3 == LB || f3 == LH || f3 == LW ||
                      f3 == LBU || f3 == LHU);
        mis = ((f3 == LH || f3 == LHU) && a[0]) ||
              (f3 == LW && a != 2'b00);
        return (ld && st) || ((ld || st) && (!legal || mis));
    endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Byte-lane steering: store mask/data shift and
// load data shift with sign or zero extension.
module ysyx_24080014_lsu_align
    import ysyx_24080014_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] din,
    output logic [31:0] rdata
);

    logic [4:0]  sh;
    logic [31:0] lane;

    assign sh   = {addr, 3'b000};
    assign lane = rword >> sh;
    assign din  = wdata << sh;

    always_comb begin
        wmask = 4'b0000;
        rdata = lane;
        unique case (funct3)
            LB: begin
                wmask = 4'b0001 << addr;
                rdata = {{24{lane[7]}}, lane[7:0]};
            end
            LH: begin
                wmask = 4'b0011 << {addr[1], 1'b0};
                rdata = {{16{lane[15]}}, lane[15:0]};
            end
            LW:  wmask = 4'b1111;
            LBU: rdata = {24'h0, lane[7:0]};
            LHU: rdata = {16'h0, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one outstanding access, FSM drives the
// memory responder handshake and holds the result for writeback.
module ysyx_24080014_lsu
    import ysyx_24080014_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic        mem_valid,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_din,
    input  logic        mem_ready,
    input  logic [31:0] mem_dout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t  state, state_n;
    logic        ld_q, st_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [CW-1:0] cnt;
    logic [3:0]  a_mask;
    logic [31:0] a_din, a_rdata;
    logic        bad, tmo, in_req, st_req;

    ysyx_24080014_lsu_align u_align (
        .funct3 (f3_q),
        .addr   (addr_q[1:0]),
        .wdata  (wdata_q),
        .rword  (mem_dout),
        .wmask  (a_mask),
        .din    (a_din),
        .rdata  (a_rdata)
    );

    assign bad = access_bad(in_load, in_store, in_funct3, in_addr[1:0]);
    assign tmo = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: if (in_valid) begin
                    ld_q    <= in_load;
                    st_q    <= in_store;
                    f3_q    <= in_funct3;
                    addr_q  <= in_addr;
                    wdata_q <= in_wdata;
                    err_q   <= bad;
                    rdata_q <= '0;
                    cnt     <= '0;
                end
                REQ: if (mem_ready) begin
                    rdata_q <= ld_q ? a_rdata : '0;
                end else if (tmo) begin
                    err_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid)
                state_n = (bad || (!in_load && !in_store)) ? RESP : REQ;
            REQ:  if (mem_ready || tmo) state_n = ACK;
            ACK:  state_n = RESP;
            RESP: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address, mask and data are only driven while a request is on the bus.
    assign in_req    = (state == REQ);
    assign st_req    = in_req && st_q;
    assign in_ready  = (state == IDLE);
    assign mem_wen   = st_req;
    assign mem_ren   = in_req && ld_q;
    assign mem_valid = (state == ACK);
    assign mem_waddr = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_raddr = mem_waddr;
    assign mem_wmask = st_req ? {4'b0000, a_mask} : 8'h00;
    assign mem_din   = st_req ? a_din : '0;
    assign out_valid = (state == RESP);
    assign out_rdata = out_valid ? rdata_q : '0;
    assign out_err   = out_valid && err_q;

endmodule
